// File: rtl/servo_pkg.sv
// Shared types and constants for the servo PWM driver: intake FSM states,
// instruction field positions and channel configuration.
package servo_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StRelease,
        StWaitLow
    } intake_state_e;

    localparam int unsigned CH_HI  = 9;
    localparam int unsigned CH_LO  = 8;
    localparam int unsigned POS_HI = 7;
    localparam int unsigned POS_LO = 0;

    localparam int unsigned N_CH       = 4;
    localparam logic [7:0]  POS_CENTRE = 8'd128;

    // Frame counter width; covers frames of up to 2^20 cycles.
    localparam int unsigned CNT_W = 20;

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo output: holds the frame-aligned position, derives the pulse width
// and registers the PWM level against the shared frame counter.
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int unsigned MIN_CYC  = 50_000,
    parameter int unsigned STEP_CYC = 196
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [CNT_W-1:0] frame_cnt_i,
    input  logic             copy_i,
    input  logic [7:0]       pending_i,
    input  logic             en_i,
    output logic             pwm_o
);

    localparam logic [7:0] Step = 8'(STEP_CYC);

    logic [7:0]       shadow_q, shadow_d;
    logic [15:0]      prod;
    logic [CNT_W-1:0] width;
    logic             pwm_q, pwm_d;

    always_comb begin
        shadow_d = copy_i ? pending_i : shadow_q;
        prod     = {8'd0, shadow_q} * {8'd0, Step};
        width    = CNT_W'(MIN_CYC) + CNT_W'(prod);
        pwm_d    = en_i && (frame_cnt_i < width);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shadow_q <= POS_CENTRE;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_pwm_driver.sv
// Four-channel servo PWM driver fed by a serial instruction receiver.
// Optional frame watchdog enabled by defining SERVO_FAILSAFE_EN.
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CYC      = 1_000_000,
    parameter int unsigned MIN_CYC        = 50_000,
    parameter int unsigned STEP_CYC       = 196,
    parameter int unsigned TIMEOUT_FRAMES = 50
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instruction_ready,
    input  logic [9:0]      instruction,
    output logic            rx_reset,
    output logic [N_CH-1:0] pwm_out,
    output logic            frame_start,
    output logic [7:0]      cmd_count,
    output logic            failsafe
);

    if ((MIN_CYC + 255 * STEP_CYC >= FRAME_CYC) || (TIMEOUT_FRAMES == 0)) begin : g_param_check
        $error("servo_pwm_driver: invalid timing parameters");
    end

    intake_state_e    state_q;
    logic [9:0]       instr_q;
    logic [7:0]       pending_q [N_CH];
    logic [7:0]       cmd_count_q;
    logic             rx_reset_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             frame_last;
    logic             capture;
    logic             pwm_en;

    assign capture    = (state_q == StCapture);
    assign frame_last = (frame_cnt_q == CNT_W'(FRAME_CYC - 1));

    // Intake handshake: latch the word, apply it, then pulse rx_reset for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            instr_q     <= '0;
            cmd_count_q <= '0;
            rx_reset_q  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                pending_q[i] <= POS_CENTRE;
            end
        end else begin
            rx_reset_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (instruction_ready) begin
                        instr_q <= instruction;
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    pending_q[instr_q[CH_HI:CH_LO]] <= instr_q[POS_HI:POS_LO];
                    cmd_count_q <= cmd_count_q + 8'd1;
                    rx_reset_q  <= 1'b1;
                    state_q     <= StRelease;
                end
                StRelease: begin
                    state_q <= StWaitLow;
                end
                StWaitLow: begin
                    if (!instruction_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_last ? '0 : frame_cnt_q + CNT_W'(1);
        end
    end

    // Gated by reset so the pulse marks the first live cycle of frame 0.
    assign frame_start = !reset && (frame_cnt_q == '0);
    assign rx_reset    = rx_reset_q;
    assign cmd_count   = cmd_count_q;

`ifdef SERVO_FAILSAFE_EN
    localparam int unsigned SilentW = $clog2(TIMEOUT_FRAMES + 1);

    logic [SilentW-1:0] silent_q, silent_d;
    logic               failsafe_q, failsafe_d;
    logic               mute_q, mute_d;

    // Mute only changes at frame boundaries so no pulse is ever truncated.
    always_comb begin
        silent_d   = silent_q;
        failsafe_d = failsafe_q;
        if (capture) begin
            silent_d   = '0;
            failsafe_d = 1'b0;
        end else if (frame_last && !failsafe_q) begin
            silent_d   = silent_q + SilentW'(1);
            failsafe_d = (silent_d == SilentW'(TIMEOUT_FRAMES));
        end
        mute_d = frame_last ? failsafe_d : mute_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            silent_q   <= '0;
            failsafe_q <= 1'b0;
            mute_q     <= 1'b0;
        end else begin
            silent_q   <= silent_d;
            failsafe_q <= failsafe_d;
            mute_q     <= mute_d;
        end
    end

    assign failsafe = failsafe_q;
    assign pwm_en   = !mute_q;
`else
    assign failsafe = 1'b0;
    assign pwm_en   = 1'b1;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        servo_pwm_channel #(
            .MIN_CYC  (MIN_CYC),
            .STEP_CYC (STEP_CYC)
        ) u_ch (
            .clk_i       (clk),
            .reset_i     (reset),
            .frame_cnt_i (frame_cnt_q),
            .copy_i      (frame_last),
            .pending_i   (pending_q[i]),
            .en_i        (pwm_en),
            .pwm_o       (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed bench for servo_pwm_driver with a short 1000-cycle frame.
module tb_servo_pwm_driver;

    localparam int unsigned FRAME = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instruction_ready = 1'b0;
    logic [9:0] instruction = '0;
    logic       rx_reset;
    logic [3:0] pwm_out;
    logic       frame_start;
    logic [7:0] cmd_count;
    logic       failsafe;

    int total = 0;
    int bad = 0;
    int cur_w[4];
    int last_w[4];
    int cyc = 0;
    int start_cyc = 0;
    int last_period = 0;
    int rx_pulses = 0;

    servo_pwm_driver #(
        .FRAME_CYC      (FRAME),
        .MIN_CYC        (100),
        .STEP_CYC       (2),
        .TIMEOUT_FRAMES (3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .instruction_ready (instruction_ready),
        .instruction       (instruction),
        .rx_reset          (rx_reset),
        .pwm_out           (pwm_out),
        .frame_start       (frame_start),
        .cmd_count         (cmd_count),
        .failsafe          (failsafe)
    );

    always #5 clk = ~clk;

    // Per-frame pulse-width and period monitor; last_w holds the frame that just ended.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_start === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                last_w[i] = cur_w[i];
                cur_w[i]  = 0;
            end
            last_period = cyc - start_cyc;
            start_cyc   = cyc;
        end
        for (int i = 0; i < 4; i++) begin
            if (pwm_out[i] === 1'b1) cur_w[i] = cur_w[i] + 1;
        end
        if (rx_reset === 1'b1) rx_pulses = rx_pulses + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        instruction_ready = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic next_frame();
        bit seen = 1'b0;
        for (int k = 0; k < FRAME + 10 && !seen; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) seen = 1'b1;
        end
        #1;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL frame_wait: frame_start got none, want one within %0d cycles", FRAME + 10);
        end
    endtask

    // Caller is at (or just after) a negedge with the intake FSM idle.
    task automatic send_cmd(input logic [1:0] ch, input logic [7:0] pos);
        instruction = {ch, pos};
        instruction_ready = 1'b1;
        @(negedge clk);
        total++;
        if (rx_reset !== 1'b0) begin
            bad++;
            $display("FAIL rx_reset_n1: got %b want 0", rx_reset);
        end
        @(negedge clk);
        total++;
        if (rx_reset !== 1'b1) begin
            bad++;
            $display("FAIL rx_reset_n2: got %b want 1", rx_reset);
        end
        @(negedge clk);
        total++;
        if (rx_reset !== 1'b0) begin
            bad++;
            $display("FAIL rx_reset_n3: got %b want 0", rx_reset);
        end
        instruction_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int exp_w[4] = '{356, 356, 356, 356};
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total += 5;
        if (pwm_out !== 4'h0) begin bad++; $display("FAIL rst_pwm: got %h want 0", pwm_out); end
        if (rx_reset !== 1'b0) begin bad++; $display("FAIL rst_rx: got %b want 0", rx_reset); end
        if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs: got %b want 0", frame_start); end
        if (cmd_count !== 8'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", cmd_count); end
        if (failsafe !== 1'b0) begin bad++; $display("FAIL rst_failsafe: got %b want 0", failsafe); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total += 2;
        if (frame_start !== 1'b1) begin bad++; $display("FAIL first_fs: got %b want 1", frame_start); end
        if (pwm_out !== 4'h0) begin bad++; $display("FAIL first_pwm: got %h want 0", pwm_out); end
        @(negedge clk);
        total += 2;
        if (frame_start !== 1'b0) begin bad++; $display("FAIL second_fs: got %b want 0", frame_start); end
        if (pwm_out !== 4'hf) begin bad++; $display("FAIL pwm_rise: got %h want f", pwm_out); end
        next_frame();
        next_frame();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (last_w[i] !== exp_w[i]) begin
                bad++;
                $display("FAIL reset_width ch%0d: got %0d want %0d", i, last_w[i], exp_w[i]);
            end
        end
        total += 2;
        if (last_period !== 1000) begin bad++; $display("FAIL period: got %0d want 1000", last_period); end
        if (cmd_count !== 8'd0) begin bad++; $display("FAIL idle_cnt: got %0d want 0", cmd_count); end
    endtask

    task automatic test_single_cmd();
        int exp_old[4] = '{356, 356, 356, 356};
        int exp_new[4] = '{356, 610, 356, 356};
        int rx0 = rx_pulses;
        send_cmd(2'd1, 8'hff);
        #1;
        total += 2;
        if (rx_pulses - rx0 !== 1) begin bad++; $display("FAIL single_rx: got %0d want 1", rx_pulses - rx0); end
        if (cmd_count !== 8'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", cmd_count); end
        next_frame();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (last_w[i] !== exp_old[i]) begin
                bad++;
                $display("FAIL single_old ch%0d: got %0d want %0d", i, last_w[i], exp_old[i]);
            end
        end
        next_frame();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (last_w[i] !== exp_new[i]) begin
                bad++;
                $display("FAIL single_new ch%0d: got %0d want %0d", i, last_w[i], exp_new[i]);
            end
        end
    endtask

    task automatic test_hold_ready();
        int rx0;
        do_reset();
        @(negedge clk);
        rx0 = rx_pulses;
        instruction = {2'd2, 8'd50};
        instruction_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (rx_reset !== 1'b1) begin bad++; $display("FAIL hold_rx_pulse: got %b want 1", rx_reset); end
        repeat (20) @(negedge clk);
        instruction_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total += 2;
        if (rx_pulses - rx0 !== 1) begin bad++; $display("FAIL hold_rx_count: got %0d want 1", rx_pulses - rx0); end
        if (cmd_count !== 8'd1) begin bad++; $display("FAIL hold_cnt: got %0d want 1", cmd_count); end
        next_frame();
        next_frame();
        total++;
        if (last_w[2] !== 200) begin bad++; $display("FAIL hold_width: got %0d want 200", last_w[2]); end
    endtask

    task automatic test_frame_boundary();
        do_reset();
        @(negedge clk);
        next_frame();
        repeat (998) @(negedge clk);
        send_cmd(2'd3, 8'd10);
        total++;
        if (cmd_count !== 8'd1) begin bad++; $display("FAIL bnd_cnt: got %0d want 1", cmd_count); end
        next_frame();
        total++;
        if (last_w[3] !== 356) begin bad++; $display("FAIL bnd_old: got %0d want 356", last_w[3]); end
        next_frame();
        total += 2;
        if (last_w[3] !== 120) begin bad++; $display("FAIL bnd_new: got %0d want 120", last_w[3]); end
        if (last_w[0] !== 356) begin bad++; $display("FAIL bnd_other: got %0d want 356", last_w[0]); end
    endtask

    task automatic test_back_to_back();
        int exp_w[4] = '{500, 356, 100, 100};
        do_reset();
        @(negedge clk);
        next_frame();
        send_cmd(2'd0, 8'd0);
        send_cmd(2'd2, 8'd0);
        send_cmd(2'd3, 8'd0);
        send_cmd(2'd0, 8'd200);
        #1;
        total++;
        if (cmd_count !== 8'd4) begin bad++; $display("FAIL b2b_cnt: got %0d want 4", cmd_count); end
        next_frame();
        total++;
        if (last_w[0] !== 356) begin bad++; $display("FAIL b2b_old: got %0d want 356", last_w[0]); end
        next_frame();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (last_w[i] !== exp_w[i]) begin
                bad++;
                $display("FAIL b2b_width ch%0d: got %0d want %0d", i, last_w[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (50) @(negedge clk);
        total++;
        if (pwm_out !== 4'hf) begin bad++; $display("FAIL mid_pre: got %h want f", pwm_out); end
        reset = 1'b1;
        @(negedge clk);
        total += 2;
        if (pwm_out !== 4'h0) begin bad++; $display("FAIL mid_pwm: got %h want 0", pwm_out); end
        if (cmd_count !== 8'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", cmd_count); end
        @(posedge clk);
        #1 reset = 1'b0;
        next_frame();
        next_frame();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (last_w[i] !== 356) begin
                bad++;
                $display("FAIL mid_width ch%0d: got %0d want 356", i, last_w[i]);
            end
        end
    endtask

`ifdef SERVO_FAILSAFE_EN
    task automatic test_failsafe();
        int exp_w[4] = '{356, 300, 356, 356};
        do_reset();
        @(negedge clk);
        next_frame();
        next_frame();
        total++;
        if (failsafe !== 1'b0) begin bad++; $display("FAIL fs_early: got %b want 0", failsafe); end
        next_frame();
        total++;
        if (failsafe !== 1'b1) begin bad++; $display("FAIL fs_set: got %b want 1", failsafe); end
        next_frame();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (last_w[i] !== 0) begin bad++; $display("FAIL fs_mute ch%0d: got %0d want 0", i, last_w[i]); end
        end
        send_cmd(2'd1, 8'd100);
        #1;
        total++;
        if (failsafe !== 1'b0) begin bad++; $display("FAIL fs_clear: got %b want 0", failsafe); end
        next_frame();
        total++;
        if (last_w[0] !== 0) begin bad++; $display("FAIL fs_hold: got %0d want 0", last_w[0]); end
        next_frame();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (last_w[i] !== exp_w[i]) begin
                bad++;
                $display("FAIL fs_resume ch%0d: got %0d want %0d", i, last_w[i], exp_w[i]);
            end
        end
    endtask
`else
    task automatic test_no_failsafe();
        do_reset();
        @(negedge clk);
        repeat (4) next_frame();
        total += 2;
        if (failsafe !== 1'b0) begin bad++; $display("FAIL nofs_flag: got %b want 0", failsafe); end
        if (last_w[1] !== 356) begin bad++; $display("FAIL nofs_width: got %0d want 356", last_w[1]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_cmd();
        test_hold_ready();
        test_frame_boundary();
        test_back_to_back();
        test_reset_mid();
`ifdef SERVO_FAILSAFE_EN
        test_failsafe();
`else
        test_no_failsafe();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
